// File: rtl/onn_pkg.sv
// Shared constants for the ONN serial pattern interface: grid size,
// classification width and the transmitter's state encoding.
package onn_pkg;

    localparam int N_NEURONS = 15;
    localparam int PHASE_W   = 4;
    localparam int NUM_W     = 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

endpackage

// File: rtl/onn_piso_shift.sv
// N-bit parallel-in/serial-out register, index 0 emitted first, with a
// registered serial output that drops to 0 once every bit has been shifted.
module onn_piso_shift
    import onn_pkg::*;
#(
    parameter int N = N_NEURONS
) (
    input  logic         sclk,
    input  logic         re,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] par_in,
    output logic         ser_out
);

    logic [N-1:0] sr;

    // The load places bit 0 straight on ser_out so it appears in the first
    // load cycle; zero fill makes the shift after the last bit emit 0.
    always_ff @(posedge sclk) begin
        if (re) begin
            sr      <= '0;
            ser_out <= 1'b0;
        end else if (load) begin
            ser_out <= par_in[0];
            sr      <= {1'b0, par_in[N-1:1]};
        end else if (shift) begin
            ser_out <= sr[0];
            sr      <= {1'b0, sr[N-1:1]};
        end
    end

endmodule

// File: rtl/onn_pattern_tx.sv
// Serial pattern transmitter: accepts a parallel pattern, shifts it into the
// ONN with load high, waits a settle interval and captures the classification.
module onn_pattern_tx
    import onn_pkg::*;
#(
    parameter int N             = N_NEURONS,
    parameter int SETTLE_CYCLES = 256,
    parameter int CNT_W         = 9
) (
    input  logic             sclk,
    input  logic             re,
    input  logic [N-1:0]     pat_in,
    input  logic             pat_valid,
    output logic             pat_ready,
    output logic             data_out,
    output logic             load_out,
    input  logic [NUM_W-1:0] num_in,
    output logic [NUM_W-1:0] result_num,
    output logic             result_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;

    // pat_ready is a pure decode of the state register, so it carries no
    // combinational path from any input.
    assign pat_ready = (state == IDLE);
    assign busy      = (state == SHIFT) || (state == SETTLE);
    assign accept    = pat_ready && pat_valid;

    onn_piso_shift #(.N(N)) u_piso (
        .sclk    (sclk),
        .re      (re),
        .load    (accept),
        .shift   (state == SHIFT),
        .par_in  (pat_in),
        .ser_out (data_out)
    );

    always_ff @(posedge sclk) begin
        if (re) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            load_out     <= 1'b0;
            result_num   <= '0;
            result_valid <= 1'b0;
        end else begin
            // NOTE: default-low then set in one branch makes a single-cycle pulse.
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pat_valid) begin
                        state    <= SHIFT;
                        bit_cnt  <= '0;
                        load_out <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        state    <= SETTLE;
                        wait_cnt <= '0;
                        load_out <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state        <= IDLE;
                        result_num   <= num_in;
                        result_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    load_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onn_pattern_tx.sv
// Self-checking bench for onn_pattern_tx: vector table, directed corner
// sequences and a randomized run against a cycle-offset reference model.
module tb_onn_pattern_tx;

    localparam int N     = 15;
    localparam int S     = 4;
    localparam int CNT_W = 9;

    logic         sclk = 1'b0;
    logic         re;
    logic [N-1:0] pat_in;
    logic         pat_valid;
    logic         pat_ready;
    logic         data_out;
    logic         load_out;
    logic [1:0]   num_in;
    logic [1:0]   result_num;
    logic         result_valid;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sclk = ~sclk;

    onn_pattern_tx #(.N(N), .SETTLE_CYCLES(S), .CNT_W(CNT_W)) dut (
        .sclk         (sclk),
        .re           (re),
        .pat_in       (pat_in),
        .pat_valid    (pat_valid),
        .pat_ready    (pat_ready),
        .data_out     (data_out),
        .load_out     (load_out),
        .num_in       (num_in),
        .result_num   (result_num),
        .result_valid (result_valid),
        .busy         (busy)
    );

    typedef struct {
        logic [N-1:0] pat;
        logic [1:0]   num;
        logic [0:N-1] exp_stream;  // leftmost literal bit is sent first
        logic [1:0]   exp_num;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Pixel k of the pattern goes out in the k-th load cycle.
    function automatic logic [0:N-1] to_stream(input logic [N-1:0] p);
        logic [0:N-1] s;
        for (int k = 0; k < N; k++) s[k] = p[k];
        return s;
    endfunction

    // Entered in the first cycle after the accepting edge; leaves the bench
    // in the result_valid cycle without advancing past it.
    task automatic transfer(input string tag, input logic [0:N-1] exp_stream,
                            input logic [1:0] late_num, input logic [1:0] exp_num,
                            input logic hold_valid, input logic [N-1:0] busy_pat);
        pat_valid = hold_valid;
        if (hold_valid) pat_in = busy_pat;
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s shift bit %0d {load,data,ready,busy}", tag, k),
                  32'({load_out, data_out, pat_ready, busy}),
                  32'({1'b1, exp_stream[k], 1'b0, 1'b1}));
            tick();
        end
        for (int j = 0; j < S; j++) begin
            if (j == S - 1) num_in = late_num;
            check($sformatf("%s settle %0d {load,data,ready,busy,rv}", tag, j),
                  32'({load_out, data_out, pat_ready, busy, result_valid}),
                  32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
            tick();
        end
        check($sformatf("%s result {rv,num,ready,busy,load}", tag),
              32'({result_valid, result_num, pat_ready, busy, load_out}),
              32'({1'b1, exp_num, 1'b1, 1'b0, 1'b0}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{15'h0001, 2'b00, 15'b100000000000000, 2'b00};
        vecs[1] = '{15'h4000, 2'b11, 15'b000000000000001, 2'b11};
        vecs[2] = '{15'h0003, 2'b10, 15'b110000000000000, 2'b10};
        vecs[3] = '{15'h7FFF, 2'b01, 15'b111111111111111, 2'b01};
        vecs[4] = '{15'h0000, 2'b10, 15'b000000000000000, 2'b10};
        vecs[5] = '{15'h000D, 2'b01, 15'b101100000000000, 2'b01};

        // Reset held 3 cycles with a pattern offered: nothing is accepted.
        re = 1'b1; pat_valid = 1'b1; pat_in = 15'h7FFF; num_in = 2'b00;
        repeat (3) tick();
        check("reset {ready,load,data,busy,rv,num}",
              32'({pat_ready, load_out, data_out, busy, result_valid, result_num}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}));
        re = 1'b0; pat_valid = 1'b0;
        tick();
        check("after reset idle {ready,busy,load}",
              32'({pat_ready, busy, load_out}), 32'({1'b1, 1'b0, 1'b0}));

        // Single symmetric pattern, result in cycle T+20 only.
        pat_in = 15'b111_101_101_101_111; num_in = 2'b01; pat_valid = 1'b1;
        tick();
        transfer("single", 15'b111101101101111, 2'b01, 2'b01, 1'b0, '0);
        tick();
        check("single post {rv,num,busy}",
              32'({result_valid, result_num, busy}), 32'({1'b0, 2'b01, 1'b0}));

        // Pattern offers while busy are ignored; exactly one result.
        pat_in = 15'h1234; num_in = 2'b10; pat_valid = 1'b1;
        tick();
        transfer("busy", to_stream(15'h1234), 2'b10, 2'b10, 1'b1, 15'h7FFF);
        pat_valid = 1'b0;
        tick();
        check("busy post1 {rv,busy,ready}",
              32'({result_valid, busy, pat_ready}), 32'({1'b0, 1'b0, 1'b1}));
        tick();
        check("busy post2 {rv,busy}", 32'({result_valid, busy}), 32'({1'b0, 1'b0}));

        // Back-to-back: B accepted in A's result cycle, first bit next cycle.
        pat_in = 15'h0F01; num_in = 2'b11; pat_valid = 1'b1;
        tick();
        transfer("b2b A", to_stream(15'h0F01), 2'b11, 2'b11, 1'b1, 15'h5A3C);
        num_in = 2'b01;
        tick();
        transfer("b2b B", to_stream(15'h5A3C), 2'b01, 2'b01, 1'b0, '0);
        tick();
        check("b2b post {rv,busy}", 32'({result_valid, busy}), 32'({1'b0, 1'b0}));

        // Reset at shift bit 7 aborts with no result.
        pat_in = 15'h2AAA; pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
        repeat (7) tick();
        check("midreset at bit7 load", 32'(load_out), 32'(1'b1));
        re = 1'b1;
        tick();
        re = 1'b0;
        check("midreset {ready,load,data,busy,rv,num}",
              32'({pat_ready, load_out, data_out, busy, result_valid, result_num}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}));
        begin
            logic saw_rv;
            saw_rv = 1'b0;
            for (int i = 0; i < N + S + 3; i++) begin
                tick();
                if (result_valid || busy) saw_rv = 1'b1;
            end
            check("midreset no partial result/activity", 32'(saw_rv), 32'(1'b0));
        end
        pat_in = 15'h0003; num_in = 2'b10; pat_valid = 1'b1;
        tick();
        transfer("after reset", to_stream(15'h0003), 2'b10, 2'b10, 1'b0, '0);

        // Capture uses num_in from the last settle cycle, then holds.
        pat_in = 15'h4001; num_in = 2'b10; pat_valid = 1'b1;
        tick();
        transfer("capture", to_stream(15'h4001), 2'b11, 2'b11, 1'b0, '0);
        num_in = 2'b00;
        tick();
        check("capture hold {rv,num}", 32'({result_valid, result_num}), 32'({1'b0, 2'b11}));

        // Vector table.
        for (int i = 0; i < 6; i++) begin
            pat_in = vecs[i].pat; num_in = vecs[i].num; pat_valid = 1'b1;
            tick();
            transfer($sformatf("vec%0d", i), vecs[i].exp_stream, vecs[i].num,
                     vecs[i].exp_num, 1'b0, '0);
            tick();
        end

        // Randomized run: the model tracks only the acceptance cycle and the
        // pattern, deriving each cycle's outputs from the offset since it.
        re = 1'b1; pat_valid = 1'b0;
        tick();
        re = 1'b0;
        begin
            logic         active;
            int           t_acc;
            int           d;
            logic [N-1:0] mp;
            logic [1:0]   m_num;
            logic         e_load, e_data, e_busy, e_rv, e_ready;
            active = 1'b0; t_acc = 0; mp = '0; m_num = 2'b00;
            for (int c = 0; c < 800; c++) begin
                re        = ($urandom_range(0, 199) == 0);
                pat_valid = ($urandom_range(0, 3) == 0);
                pat_in    = N'($urandom);
                num_in    = 2'($urandom);
                d       = active ? c - t_acc : 0;
                e_load  = active && d >= 1 && d <= N;
                e_data  = 1'b0;
                if (e_load) e_data = mp[d-1];
                e_busy  = active && d >= 1 && d <= N + S;
                e_rv    = active && d == N + S + 1;
                e_ready = !e_busy;
                check($sformatf("rand c%0d {ready,load,data,busy,rv,num}", c),
                      32'({pat_ready, load_out, data_out, busy, result_valid, result_num}),
                      32'({e_ready, e_load, e_data, e_busy, e_rv, m_num}));
                if (re) begin
                    active = 1'b0;
                    m_num  = 2'b00;
                end else begin
                    if (active && d == N + S) m_num = num_in;
                    if (e_ready && pat_valid) begin
                        active = 1'b1;
                        t_acc  = c;
                        mp     = pat_in;
                    end else if (e_rv) begin
                        active = 1'b0;
                    end
                end
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onn_pattern_tx.md
Name: onn_pattern_tx

Overview:
Serial pattern transmitter that drives the ONN's serial load interface (data_in/load) from a parallel 15-pixel pattern. It accepts a 3x5 pattern over a valid/ready handshake and shifts it out one bit per cycle with load asserted. It then waits a programmable settle interval, captures the ONN's 2-bit classification, and reports it with a one-cycle valid pulse. It sits between a host/test controller and the ONN core; both run on the same sclk.

Parameters:
N, 15, number of neurons/pixels (3x5 grid)
SETTLE_CYCLES, 256, cycles to wait after the last shifted bit before sampling the class; must be >= 1
CNT_W, 9, counter width; must satisfy 2**CNT_W > max(N, SETTLE_CYCLES)

Ports:
sclk  input  1  system clock, all logic on the rising edge
re  input  1  synchronous active-high reset
pat_in  input  N  parallel pattern, index 0 first ([0:N-1] ordering, bit 0 = top-left pixel)
pat_valid  input  1  pattern offered
pat_ready  output  1  block can accept a pattern
data_out  output  1  serial bit to the ONN data_in
load_out  output  1  load strobe to the ONN load
num_in  input  2  classification from the ONN num
result_num  output  2  captured classification
result_valid  output  1  one-cycle pulse when result_num is updated
busy  output  1  high in SHIFT or SETTLE

Behaviour:
- Clock/reset: single clock sclk; reset re is synchronous and active-high.
- Reset values: pat_ready=1, data_out=0, load_out=0, result_num=2'b00, result_valid=0, busy=0, state=IDLE, counters=0, shift register=0.
- FSM states: IDLE, SHIFT, SETTLE.
- IDLE:
  - pat_ready=1.
  - On pat_valid&&pat_ready at edge T: latch pat_in into the shift register, go to SHIFT, clear bit_cnt.
- SHIFT:
  - In cycles T+1..T+N: load_out=1 and data_out=pat[k] for cycle T+1+k (k=0..N-1, index 0 first).
  - Exactly N load cycles, no gaps.
  - After cycle T+N, go to SETTLE.
- SETTLE:
  - load_out=0, data_out=0.
  - wait_cnt counts SETTLE_CYCLES cycles, T+N+1 .. T+N+SETTLE_CYCLES.
  - At the edge ending the last settle cycle: result_num<=num_in, result_valid<=1 for exactly one cycle, state<=IDLE.
- Output timing:
  - data_out and load_out are registered, with no combinational path from inputs.
  - pat_ready=(state==IDLE) and is registered-equivalent.
  - pat_ready rises in the same cycle that result_valid is high, so back-to-back acceptance is possible at that cycle.
- Busy behaviour:
  - busy=1 in SHIFT and SETTLE.
  - pat_valid is ignored while busy, and pat_in changes while busy do not affect the transfer.
- Result hold: result_num holds its value until the next capture. result_valid is never high for two consecutive cycles.
- Reset mid-operation: re in SHIFT or SETTLE aborts the transfer. On the next cycle all outputs return to their reset values; no partial result_valid is produced.
- Simultaneous re and pat_valid: reset wins and the pattern is not accepted.
- Counter wrap: counters never wrap (guaranteed by the CNT_W rule). bit_cnt and wait_cnt are cleared on entry to their states.

Decomposition:
- Shared package onn_pkg holds:
  - N_NEURONS=15
  - PHASE_W=4
  - NUM_W=2
  - the state encoding localparams (IDLE=2'd0, SHIFT=2'd1, SETTLE=2'd2)
- One natural sub-module: onn_piso_shift, an N-bit parallel-in/serial-out register with a load enable and a shift enable, emitting index 0 first.
- FSM and counters stay in the top module.

Test Plan:
1. Reset: hold re for 3 cycles -> pat_ready=1, load_out=0, data_out=0, result_valid=0, result_num=0; pat_valid=1 during re is not accepted.
2. Single pattern: pat_in=15'b111_101_101_101_111 accepted at T -> load_out=1 for cycles T+1..T+15 with data_out sequence 1,1,1,1,0,1,1,0,1,1,0,1,1,1,1; load_out=0 at T+16. With num_in held at 2'b01 and SETTLE_CYCLES=4: result_valid=1 in cycle T+20 only, result_num=01.
3. Busy rejection: assert pat_valid with 15'h7FFF during SHIFT and SETTLE -> pat_ready=0, serial stream still equals the first pattern, and only one result is produced.
4. Back-to-back: hold pat_valid=1 with patterns A then B -> B is accepted in A's result_valid cycle, and B's first load cycle immediately follows, with no lost bits.
5. Reset mid-shift: assert re at shift bit 7 -> load_out=0 next cycle, no result_valid, pat_ready=1; a new pattern then transfers correctly.
6. Capture timing: change num_in from 2'b10 to 2'b11 one cycle before the capture edge -> result_num=11; a change after the capture edge leaves result_num unchanged.
